pipe_out_buffer: RTL and testbench
==================================

Name: pipe_out_buffer

Overview:
- Downstream consumer of the 3-stage arithmetic pipeline pipe_ex, which computes F = ((A+B)-C)*D with no valid and no stall.
- Tracks which pipeline slots carry real operands using a valid delay line matched to pipe_ex latency.
- Captures valid F results into a small synchronous FIFO and presents them on a ready/valid output port.
- pipe_ex cannot be stalled, so the buffer absorbs bursts and flags overflow instead of back-pressuring.

Parameters:
- N, 10, data width of f_in/out_data; matches the pipe_ex width.
- LAT, 3, pipe_ex latency in clocks (register stages); ≥1.
- DEPTH, 4, FIFO entries; power of two, ≥2.

Ports:
- clk, input, 1, rising-edge clock shared with pipe_ex.
- rst_n, input, 1, asynchronous active-low reset.
- issue_valid, input, 1, high in the cycle A/B/C/D presented to pipe_ex are real operands.
- f_in, input, N, F output of pipe_ex.
- out_valid, output, 1, FIFO head valid.
- out_ready, input, 1, consumer accepts head.
- out_data, output, N, FIFO head value.
- count, output, $clog2(DEPTH)+1, current occupancy.
- overflow, output, 1, sticky: a valid result was dropped.
- clr_ovf, input, 1, synchronous clear of overflow.

Behaviour:
- Reset (rst_n low, async): vld_pipe all 0; FIFO empty with pointers 0; out_valid=0; out_data=0; count=0; overflow=0. Reset mid-operation discards in-flight valids and all buffered data.
- Valid delay line vld_pipe[LAT-1:0]:
  - at each edge, vld_pipe[0]<=issue_valid and vld_pipe[i]<=vld_pipe[i-1].
  - vld_pipe[LAT-1] is high exactly while f_in holds the result for the operands issued LAT edges earlier.
- push = vld_pipe[LAT-1]. On a push edge f_in is written to the FIFO.
  - Issue-to-FIFO latency: operands sampled at edge k, pushed at edge k+LAT, out_valid high after edge k+LAT.
  - No combinational bypass when empty.
- pop = out_valid & out_ready. Head advances at the edge. out_data is the registered head (read-first FIFO output), stable while out_valid & !out_ready.
- Simultaneous push and pop:
  - when not full, count is unchanged.
  - when full, the push is accepted because the pop frees the slot; no overflow.
  - when empty, pop cannot occur (out_valid=0) and the push proceeds normally.
- Full with push and no pop: result dropped, FIFO unchanged, overflow<=1.
- overflow precedence: set beats clr_ovf in the same cycle.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count ranges 0..DEPTH.
- out_data after a pop that empties the FIFO holds the last value; don't-care while out_valid=0.
- Back-to-back issue every cycle is supported: one push per clock.

Optional Feature:
- Macro PIPE_OUT_SUM_EN.
- When defined:
  - adds output port sum_out, width N+8.
  - sum_out accumulates every popped out_data, unsigned, wrapping modulo 2^(N+8).
  - cleared by rst_n and by clr_ovf.
  - updates at the pop edge, so it is visible the cycle after the pop.
- When undefined: no port and no accumulator logic.

Decomposition:
- Package pipe_pkg holds:
  - constants PIPE_N=10, PIPE_LAT=3, PIPE_DEPTH=4.
  - CNT_W derived via $clog2.
  - typedef pipe_data_t (logic [PIPE_N-1:0]).
- Sub-module pipe_fifo: generic synchronous FIFO (clk, rst_n, push, pop, din, dout, count, full, empty).
- pipe_out_buffer instantiates pipe_fifo and contains the delay line, overflow flag and optional accumulator.

Test Plan:
- Reset, then issue (A,B,C,D)=(10,12,6,3) at edge k with out_ready=1: out_valid rises after edge k+3 with out_data=48; count 1 then 0 after the pop.
- Back-to-back issue of (10,12,6,3), (10,10,5,3), (20,11,1,4), (15,10,8,2) with out_ready=1: out_data sequence 48, 45, 120, 34 on consecutive cycles; overflow stays 0.
- out_ready=0 while issuing 5 consecutive valid sets: count saturates at 4, overflow=1, the 5th result is lost. Raising out_ready then drains exactly the first 4 results in order.
- FIFO full plus push and pop in the same cycle: count stays 4, no overflow, new result appears in order. clr_ovf with no concurrent drop clears overflow next cycle.
- issue_valid pattern 1,0,1 with operands (8,15,5,0), garbage, (10,20,5,3): only 0 and 75 are pushed; the garbage-slot F is never seen.
- Assert rst_n low mid-burst with 2 entries buffered and 2 in flight: all outputs return to 0 immediately and nothing is pushed after rst_n rises. With PIPE_OUT_SUM_EN defined, popping 48, 45, 120 gives sum_out=213.

Source files
------------

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants and types for the pipe_ex output buffer slice.
//   PIPE_N      - data width of pipe_ex results
//   PIPE_LAT    - pipe_ex latency in clocks
//   PIPE_DEPTH  - output FIFO depth (power of two)
//   CNT_W       - width of an occupancy count covering 0..PIPE_DEPTH
//   pipe_data_t - one pipe_ex result word
package pipe_pkg;

    localparam int PIPE_N     = 10;
    localparam int PIPE_LAT   = 3;
    localparam int PIPE_DEPTH = 4;
    localparam int CNT_W      = $clog2(PIPE_DEPTH) + 1;

    typedef logic [PIPE_N-1:0] pipe_data_t;

endpackage

// File: rtl/pipe_fifo.sv
// pipe_fifo: generic synchronous FIFO with a registered head output.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, din   - write request and data (ignored when full unless popping)
//   pop         - read request (ignored when empty)
//   dout        - registered head value; holds its last value once empty
//   count       - occupancy 0..DEPTH
//   full, empty - occupancy flags
module pipe_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] rd_nxt;
    logic [CW-1:0] cnt;
    logic [W-1:0]  dout_q;
    logic          wr_en;
    logic          rd_en;

    assign full   = (cnt == CW'(DEPTH));
    assign empty  = (cnt == '0);
    // A pop frees the slot the same edge, so a full FIFO still takes a push.
    assign wr_en  = push && (!full || pop);
    assign rd_en  = pop && !empty;
    assign rd_nxt = rd_ptr + 1'b1;
    assign dout   = dout_q;
    assign count  = cnt;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            dout_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_nxt;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            // Head register: next stored entry, or the incoming word when it
            // becomes the head; otherwise it keeps the last value shown.
            if (rd_en) begin
                if (cnt > CW'(1)) begin
                    dout_q <= mem[rd_nxt];
                end else if (wr_en) begin
                    dout_q <= din;
                end
            end else if (wr_en && empty) begin
                dout_q <= din;
            end
        end
    end

endmodule

// File: rtl/pipe_out_buffer.sv
// pipe_out_buffer: captures valid pipe_ex results into a FIFO and presents
// them on a ready/valid port. pipe_ex cannot stall, so results arriving
// while the FIFO is full are dropped and flagged in a sticky overflow bit.
// Ports:
//   clk, rst_n         - shared clock, asynchronous active-low reset
//   issue_valid        - operands presented to pipe_ex this cycle are real
//   f_in               - F result from pipe_ex
//   out_valid/out_ready/out_data - output handshake and FIFO head
//   count              - FIFO occupancy
//   overflow, clr_ovf  - sticky drop flag and its synchronous clear
//   sum_out            - running sum of popped data (PIPE_OUT_SUM_EN only)
// Optional feature macro: PIPE_OUT_SUM_EN.
module pipe_out_buffer
    import pipe_pkg::*;
#(
    parameter int N     = PIPE_N,
    parameter int LAT   = PIPE_LAT,
    parameter int DEPTH = PIPE_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    input  logic [N-1:0]             f_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf
`ifdef PIPE_OUT_SUM_EN
    ,
    output logic [N+7:0]             sum_out
`endif
);

    logic [LAT-1:0] vld_pipe;
    logic           push;
    logic           pop;
    logic           full;
    logic           empty;

    // Valid delay line: bit LAT-1 lines up with f_in for the same operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= issue_valid;
            for (int i = 1; i < LAT; i++) begin
                vld_pipe[i] <= vld_pipe[i-1];
            end
        end
    end

    assign push      = vld_pipe[LAT-1];
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;

    pipe_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (f_in),
        .dout  (out_data),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    // A drop sets the flag even if clr_ovf is asserted on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (push && full && !pop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

`ifdef PIPE_OUT_SUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_out <= '0;
        end else if (clr_ovf) begin
            sum_out <= '0;
        end else if (pop) begin
            sum_out <= sum_out + {8'b0, out_data};
        end
    end
`endif

endmodule

// File: tb/tb_pipe_out_buffer.sv
module tb_pipe_out_buffer;
    import pipe_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             issue_valid = 1'b0;
    logic [PIPE_N-1:0] f_in;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [PIPE_N-1:0] out_data;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             clr_ovf = 1'b0;
`ifdef PIPE_OUT_SUM_EN
    logic [PIPE_N+7:0] sum_out;
`endif

    int a_op = 0, b_op = 0, c_op = 0, d_op = 0;
    logic [PIPE_N-1:0] fcalc, f_p0, f_p1, f_p2;
    logic [PIPE_N-1:0] sb[$];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    pipe_out_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .f_in        (f_in),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .count       (count),
        .overflow    (overflow),
        .clr_ovf     (clr_ovf)
`ifdef PIPE_OUT_SUM_EN
        ,
        .sum_out     (sum_out)
`endif
    );

    // Stand-in for pipe_ex: F = ((A+B)-C)*D through three register stages.
    always_comb begin
        fcalc = PIPE_N'(((a_op + b_op) - c_op) * d_op);
    end

    always @(posedge clk) begin
        f_p0 <= fcalc;
        f_p1 <= f_p0;
        f_p2 <= f_p1;
    end
    assign f_in = f_p2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every accepted head must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                chk("pop_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input int a, input int b, input int c, input int d, input bit keep);
        issue_valid = 1'b1;
        a_op = a; b_op = b; c_op = c; d_op = d;
        #0;
        if (keep) sb.push_back(PIPE_N'(((a + b) - c) * d));
        step(1);
    endtask

    task automatic idle(input int n);
        issue_valid = 1'b0;
        a_op = int'($urandom_range(0, 99));
        b_op = int'($urandom_range(0, 99));
        c_op = 0;
        d_op = int'($urandom_range(1, 7));
        step(n);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        step(2);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data", 32'(out_data), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        step(1);

        // Single issue: latency of three edges
        out_ready = 1'b1;
        issue(10, 12, 6, 3, 1'b1);
        idle(1);
        chk("lat_k1_valid", 32'(out_valid), 0);
        idle(1);
        chk("lat_k2_valid", 32'(out_valid), 0);
        idle(1);
        chk("lat_k3_valid", 32'(out_valid), 1);
        chk("lat_k3_count", 32'(count), 1);
        chk("lat_k3_data", 32'(out_data), 48);
        idle(1);
        chk("lat_k4_count", 32'(count), 0);
        chk("lat_k4_valid", 32'(out_valid), 0);

        // Back-to-back issue
        issue(10, 12, 6, 3, 1'b1);
        issue(10, 10, 5, 3, 1'b1);
        issue(20, 11, 1, 4, 1'b1);
        issue(15, 10, 8, 2, 1'b1);
        idle(3);
        chk("b2b_valid_mid", 32'(out_valid), 1);
        idle(4);
        chk("b2b_drained", 32'(sb.size()), 0);
        chk("b2b_overflow", 32'(overflow), 0);

        // Overflow: five results, no consumer
        out_ready = 1'b0;
        issue(1, 2, 0, 1, 1'b1);
        issue(2, 2, 0, 1, 1'b1);
        issue(3, 4, 0, 5, 1'b1);
        issue(9, 9, 2, 6, 1'b1);
        issue(7, 7, 7, 7, 1'b0);
        idle(3);
        chk("ovf_count", 32'(count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        out_ready = 1'b1;
        idle(5);
        chk("ovf_drain_count", 32'(count), 0);
        chk("ovf_drain_sb", 32'(sb.size()), 0);
        chk("ovf_sticky", 32'(overflow), 1);

        // clr_ovf with no concurrent drop
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("clr_ovf", 32'(overflow), 0);

        // Full plus simultaneous push and pop
        out_ready = 1'b0;
        issue(11, 0, 0, 1, 1'b1);
        issue(12, 0, 0, 1, 1'b1);
        issue(13, 0, 0, 1, 1'b1);
        issue(14, 0, 0, 1, 1'b1);
        idle(3);
        chk("full_count", 32'(count), 4);
        issue(15, 0, 0, 1, 1'b1);
        idle(2);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("pushpop_count", 32'(count), 4);
        chk("pushpop_overflow", 32'(overflow), 0);
        chk("pushpop_head", 32'(out_data), 12);

        // Drop and clr_ovf on the same edge: set wins
        issue(16, 0, 0, 1, 1'b0);
        idle(2);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("set_beats_clr", 32'(overflow), 1);
        chk("drop_count", 32'(count), 4);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("clr_after_set", 32'(overflow), 0);
        out_ready = 1'b1;
        idle(5);
        chk("full_drain_sb", 32'(sb.size()), 0);

        // Valid pattern 1,0,1 with a garbage middle slot
        issue(8, 15, 5, 0, 1'b1);
        issue_valid = 1'b0;
        a_op = 50; b_op = 13; c_op = 1; d_op = 5;
        step(1);
        issue(10, 20, 5, 3, 1'b1);
        idle(6);
        chk("gap_sb", 32'(sb.size()), 0);
        chk("gap_count", 32'(count), 0);

        // Reset mid-burst: 2 buffered, 2 in flight
        out_ready = 1'b0;
        issue(1, 1, 0, 1, 1'b0);
        issue(2, 1, 0, 1, 1'b0);
        issue(3, 1, 0, 1, 1'b0);
        issue(4, 1, 0, 1, 1'b0);
        idle(1);
        chk("pre_rst_count", 32'(count), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_count", 32'(count), 0);
        chk("midrst_data", 32'(out_data), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        step(1);
        rst_n = 1'b1;
        idle(5);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_valid", 32'(out_valid), 0);

`ifdef PIPE_OUT_SUM_EN
        out_ready = 1'b1;
        issue(10, 12, 6, 3, 1'b1);
        issue(10, 10, 5, 3, 1'b1);
        issue(20, 11, 1, 4, 1'b1);
        idle(7);
        chk("sum_out", 32'(sum_out), 213);
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
        chk("sum_clr", 32'(sum_out), 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
